// File: rtl/flag_unit.sv
// NZVC condition-flag producer: tracks in-flight ADDS/SUBS, commits ALU flags, and serves B.cond in decode.
// Optional macro FLAG_BYPASS_EN forwards pending flags to decode instead of stalling the branch.
module flag_unit #(
    parameter int COMMIT_STAGE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instruction,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic        id_flush,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    output logic        negative,
    output logic        zero,
    output logic        overflow,
    output logic        carry,
    output logic [3:0]  arch_flags,
    output logic        flag_stall
);

    localparam logic [5:0] OP_ADDS  = 6'b101010;
    localparam logic [5:0] OP_SUBS  = 6'b111010;
    localparam logic [5:0] OP_BCOND = 6'b010101;

    logic       r_exSet;
    logic       r_memSet;
    logic [3:0] r_memFlags;
    logic [3:0] r_archFlags;

    logic [5:0] w_opcode;
    logic       w_isSetFlags;
    logic       w_isBcond;
    logic       w_issue;
    logic       w_flagStall;
    logic [3:0] w_aluFlags;
    logic [3:0] w_seenFlags;
    logic       w_unused;

    assign w_opcode     = id_instruction[31:26];
    assign w_isSetFlags = (w_opcode == OP_ADDS) || (w_opcode == OP_SUBS);
    assign w_isBcond    = (w_opcode == OP_BCOND);
    assign w_aluFlags   = {alu_negative, alu_zero, alu_overflow, alu_carry};
    assign w_issue      = id_valid & ~id_stall & ~id_flush & ~w_flagStall;

    // A setter that does not issue leaves a bubble, so EX never inherits a squashed ADDS/SUBS.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exSet     <= 1'b0;
            r_memSet    <= 1'b0;
            r_memFlags  <= 4'b0000;
            r_archFlags <= 4'b0000;
        end else begin
            r_exSet <= w_issue & w_isSetFlags;
            if (COMMIT_STAGE == 2) begin
                r_memSet <= r_exSet;
                if (r_exSet) begin
                    r_memFlags <= w_aluFlags;
                end
                if (r_memSet) begin
                    r_archFlags <= r_memFlags;
                end
            end else begin
                r_memSet <= 1'b0;
                if (r_exSet) begin
                    r_archFlags <= w_aluFlags;
                end
            end
        end
    end

`ifdef FLAG_BYPASS_EN
    // Youngest pending setter wins; r_memSet is constant 0 when committing from EX.
    always_comb begin
        w_seenFlags = r_archFlags;
        if (r_exSet) begin
            w_seenFlags = w_aluFlags;
        end else if (r_memSet) begin
            w_seenFlags = r_memFlags;
        end
    end
    assign w_flagStall = 1'b0;
`else
    assign w_seenFlags = r_archFlags;
    assign w_flagStall = id_valid & w_isBcond & (r_exSet | r_memSet);
`endif

    assign w_unused = ^{id_instruction[25:0], r_memFlags, w_isBcond};

    assign negative   = w_seenFlags[3];
    assign zero       = w_seenFlags[2];
    assign overflow   = w_seenFlags[1];
    assign carry      = w_seenFlags[0];
    assign arch_flags = r_archFlags;
    assign flag_stall = w_flagStall;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: drives one stimulus stream into a COMMIT_STAGE=1 and a COMMIT_STAGE=2 instance.
// Expected values are hand-computed for both FLAG_BYPASS_EN settings.
module tb_flag_unit;

    localparam logic [5:0] ADDS  = 6'b101010;
    localparam logic [5:0] SUBS  = 6'b111010;
    localparam logic [5:0] BCOND = 6'b010101;
    localparam logic [5:0] NOP   = 6'b000000;

    typedef struct {
        int         cyc;
        logic [3:0] f1;
        logic [3:0] a1;
        logic       s1;
        logic [3:0] f2;
        logic [3:0] a2;
        logic       s2;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] idInstruction;
    logic        idValid;
    logic        idStall;
    logic        idFlush;
    logic [3:0]  aluFlags;

    logic        neg1, zero1, ovf1, car1, stall1;
    logic [3:0]  arch1;
    logic        neg2, zero2, ovf2, car2, stall2;
    logic [3:0]  arch2;

    exp_t scoreboard[$];
    int   testsRun;
    int   testsFailed;

    flag_unit #(.COMMIT_STAGE(1)) dut1 (
        .clk(clk), .reset(reset), .id_instruction(idInstruction),
        .id_valid(idValid), .id_stall(idStall), .id_flush(idFlush),
        .alu_negative(aluFlags[3]), .alu_zero(aluFlags[2]),
        .alu_overflow(aluFlags[1]), .alu_carry(aluFlags[0]),
        .negative(neg1), .zero(zero1), .overflow(ovf1), .carry(car1),
        .arch_flags(arch1), .flag_stall(stall1)
    );

    flag_unit #(.COMMIT_STAGE(2)) dut2 (
        .clk(clk), .reset(reset), .id_instruction(idInstruction),
        .id_valid(idValid), .id_stall(idStall), .id_flush(idFlush),
        .alu_negative(aluFlags[3]), .alu_zero(aluFlags[2]),
        .alu_overflow(aluFlags[1]), .alu_carry(aluFlags[0]),
        .negative(neg2), .zero(zero2), .overflow(ovf2), .carry(car2),
        .arch_flags(arch2), .flag_stall(stall2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input int cyc, input string what, input logic [3:0] got, input logic [3:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL cycle %0d %s: got %b, want %b", cyc, what, got, want);
        end
    endtask

    // m0 columns hold the stall-based expectation, m1 the bypass expectation.
    task automatic applyStimulus(
        input int cyc, input logic rst, input logic [5:0] op,
        input logic v, input logic st, input logic fl, input logic [3:0] alu,
        input logic [3:0] f1m0, input logic [3:0] f1m1, input logic [3:0] a1, input logic s1,
        input logic [3:0] f2m0, input logic [3:0] f2m1, input logic [3:0] a2, input logic s2
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        idInstruction = {op, 26'h2AAAAAA};
        idValid       = v;
        idStall       = st;
        idFlush       = fl;
        aluFlags      = alu;
        e.cyc = cyc;
        e.a1  = a1;
        e.a2  = a2;
`ifdef FLAG_BYPASS_EN
        e.f1 = f1m1;
        e.f2 = f2m1;
        e.s1 = 1'b0;
        e.s2 = 1'b0;
`else
        e.f1 = f1m0;
        e.f2 = f2m0;
        e.s1 = s1;
        e.s2 = s2;
`endif
        scoreboard.push_back(e);
    endtask

    // Monitor: the DUT presents a fresh flag view every cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (scoreboard.size() != 0) begin
                e = scoreboard.pop_front();
                checkOutput(e.cyc, "cs1_flags", {neg1, zero1, ovf1, car1}, e.f1);
                checkOutput(e.cyc, "cs1_arch", arch1, e.a1);
                checkOutput(e.cyc, "cs1_stall", {3'b000, stall1}, {3'b000, e.s1});
                checkOutput(e.cyc, "cs2_flags", {neg2, zero2, ovf2, car2}, e.f2);
                checkOutput(e.cyc, "cs2_arch", arch2, e.a2);
                checkOutput(e.cyc, "cs2_stall", {3'b000, stall2}, {3'b000, e.s2});
            end
        end
    end

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        reset         = 1'b1;
        idInstruction = {ADDS, 26'h2AAAAAA};
        idValid       = 1'b1;
        idStall       = 1'b0;
        idFlush       = 1'b0;
        aluFlags      = 4'b1111;

        //             cyc rst op     v  st fl alu      f1m0     f1m1     a1       s1    f2m0     f2m1     a2       s2
        applyStimulus( 1, 1, ADDS,  1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        applyStimulus( 2, 0, NOP,   1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        applyStimulus( 3, 0, NOP,   1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        applyStimulus( 4, 0, SUBS,  1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        applyStimulus( 5, 0, BCOND, 1, 0, 0, 4'b1001, 4'b0000, 4'b1001, 4'b0000, 1, 4'b0000, 4'b1001, 4'b0000, 1);
        applyStimulus( 6, 0, BCOND, 1, 0, 0, 4'b0110, 4'b1001, 4'b1001, 4'b1001, 0, 4'b0000, 4'b1001, 4'b0000, 1);
        applyStimulus( 7, 0, BCOND, 1, 0, 0, 4'b0110, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001, 4'b1001, 4'b1001, 0);
        applyStimulus( 8, 0, ADDS,  1, 0, 1, 4'b0011, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001, 4'b1001, 4'b1001, 0);
        applyStimulus( 9, 0, NOP,   1, 0, 0, 4'b0011, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001, 4'b1001, 4'b1001, 0);
        applyStimulus(10, 0, ADDS,  1, 1, 0, 4'b0011, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001, 4'b1001, 4'b1001, 0);
        applyStimulus(11, 0, ADDS,  1, 1, 0, 4'b0011, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001, 4'b1001, 4'b1001, 0);
        applyStimulus(12, 0, ADDS,  1, 1, 1, 4'b0011, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001, 4'b1001, 4'b1001, 0);
        applyStimulus(13, 0, ADDS,  1, 0, 0, 4'b0000, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001, 4'b1001, 4'b1001, 0);
        applyStimulus(14, 0, NOP,   1, 0, 0, 4'b0011, 4'b1001, 4'b0011, 4'b1001, 0, 4'b1001, 4'b0011, 4'b1001, 0);
        applyStimulus(15, 0, NOP,   1, 0, 0, 4'b1111, 4'b0011, 4'b0011, 4'b0011, 0, 4'b1001, 4'b0011, 4'b1001, 0);
        applyStimulus(16, 0, NOP,   1, 0, 0, 4'b1111, 4'b0011, 4'b0011, 4'b0011, 0, 4'b0011, 4'b0011, 4'b0011, 0);
        applyStimulus(17, 0, ADDS,  1, 0, 0, 4'b1111, 4'b0011, 4'b0011, 4'b0011, 0, 4'b0011, 4'b0011, 4'b0011, 0);
        applyStimulus(18, 0, SUBS,  1, 0, 0, 4'b0100, 4'b0011, 4'b0100, 4'b0011, 0, 4'b0011, 4'b0100, 4'b0011, 0);
        applyStimulus(19, 0, BCOND, 1, 0, 0, 4'b1000, 4'b0100, 4'b1000, 4'b0100, 1, 4'b0011, 4'b1000, 4'b0011, 1);
        applyStimulus(20, 0, BCOND, 1, 0, 0, 4'b0001, 4'b1000, 4'b1000, 4'b1000, 0, 4'b0100, 4'b1000, 4'b0100, 1);
        applyStimulus(21, 0, BCOND, 1, 0, 0, 4'b0001, 4'b1000, 4'b1000, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0);
        applyStimulus(22, 0, SUBS,  1, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0);
        applyStimulus(23, 0, BCOND, 1, 0, 0, 4'b0110, 4'b1000, 4'b0110, 4'b1000, 1, 4'b1000, 4'b0110, 4'b1000, 1);
        applyStimulus(24, 1, BCOND, 1, 0, 0, 4'b0001, 4'b0110, 4'b0110, 4'b0110, 0, 4'b1000, 4'b0110, 4'b1000, 1);
        applyStimulus(25, 0, BCOND, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        applyStimulus(26, 0, ADDS,  0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        applyStimulus(27, 0, NOP,   1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        applyStimulus(28, 0, NOP,   1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < 10 && scoreboard.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        testsRun++;
        if (scoreboard.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", scoreboard.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the condition-flag interface consumed by PC_control (negative, zero, overflow, plus the carry flag that branch logic needs for HS/LO/HI/LS).
- Tracks in-flight flag-setting instructions (ADDS, SUBS) through the pipeline and commits ALU flags to the architectural NZVC register.
- Presents the correct flags to a B.cond sitting in decode, either by bypassing or by requesting a stall.

Parameters:
- COMMIT_STAGE, 1, pipeline stage after which flags commit. 1 = end of EX; 2 = end of MEM, with an extra EX->MEM flag register. Only 1 and 2 are legal.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_instruction  in  32  instruction in decode; opcode in bits [31:26]
- id_valid  in  1  decode slot holds a real instruction
- id_stall  in  1  hazard unit holds decode this cycle; no issue
- id_flush  in  1  squash decode-slot instruction; no issue
- alu_negative  in  1  N from ALU for the instruction in EX
- alu_zero  in  1  Z from ALU for the instruction in EX
- alu_overflow  in  1  V from ALU for the instruction in EX
- alu_carry  in  1  C from ALU for the instruction in EX
- negative  out  1  N as seen by the decode-stage branch
- zero  out  1  Z as seen by the decode-stage branch
- overflow  out  1  V as seen by the decode-stage branch
- carry  out  1  C as seen by the decode-stage branch
- arch_flags  out  4  committed {N,Z,V,C}
- flag_stall  out  1  decode B.cond must wait; hazard unit holds PC and IF/ID

Behaviour:
- Decode rules:
  - is_setflags = opcode 101010 (ADDS) or 111010 (SUBS).
  - is_bcond = opcode 010101.
  - All other opcodes do not touch flags.
- issue = id_valid & ~id_stall & ~id_flush & ~flag_stall.
- ex_set register: ex_set <= issue & is_setflags. A non-issuing cycle loads a bubble (0).
- COMMIT_STAGE=1:
  - If ex_set, arch_flags <= {alu_negative, alu_zero, alu_overflow, alu_carry} at the end of that cycle.
  - Commit latency: flags are architectural 2 edges after issue.
- COMMIT_STAGE=2:
  - mem_set <= ex_set; mem_flags <= ALU flags when ex_set.
  - If mem_set, arch_flags <= mem_flags.
  - Commit latency: 3 edges after issue.
- Flags with bypass (macro defined):
  - Outputs select the youngest pending setter: ex_set ? ALU flags : (mem_set ? mem_flags : arch_flags).
  - The mem_set term exists only when COMMIT_STAGE=2.
- Flag ordering: a flag-setting instruction never sees its own flags; only older setters count.
- flag_stall:
  - Depends only on id_valid, is_bcond and internal state.
  - Never depends on id_stall or id_flush, to avoid combinational loops.
- Reset:
  - ex_set, mem_set, mem_flags and arch_flags clear to 0.
  - Outputs read 0000 the cycle after reset; flag_stall is 0 after reset.
  - Reset mid-operation discards every pending setter; nothing commits.
- Simultaneous events:
  - Flush and stall in the same cycle produce a bubble.
  - A commit in the same cycle as a new issue: the commit uses the older instruction's flags, and the new setter enters EX.
  - Back-to-back setters commit in order; the last one wins.

Optional Feature:
- Macro: FLAG_BYPASS_EN
- Defined:
  - Bypass mux as above.
  - flag_stall tied to 0.
- Undefined:
  - negative/zero/overflow/carry = arch_flags only.
  - flag_stall = id_valid & is_bcond & (ex_set | mem_set).
  - The stall holds until all older setters commit: 1 cycle for COMMIT_STAGE=1, up to 2 cycles for COMMIT_STAGE=2.

Test Plan:
1. Reset for 2 cycles with id_valid=1 and ADDS in decode -> arch_flags=0000, outputs 0, flag_stall=0; no commit after reset release until re-issue.
2. FLAG_BYPASS_EN, COMMIT_STAGE=1: SUBS issues at cycle 0; at cycle 1 the ALU drives N=1 Z=0 V=0 C=1 and B.cond is in decode -> negative=1 and carry=1 in cycle 1, flag_stall=0; arch_flags=1001 from cycle 2.
3. Macro undefined, same sequence -> flag_stall=1 in cycle 1 with outputs showing old arch 0000; cycle 2 flag_stall=0, outputs 1001.
4. ADDS in decode with id_flush=1, next cycle ALU drives Z=1 -> arch_flags unchanged at 0000; repeat with id_stall=1 for 3 cycles, then release -> commit exactly 2 edges after release.
5. FLAG_BYPASS_EN, COMMIT_STAGE=2: ADDS (ALU Z=1) then SUBS (ALU N=1) back-to-back, B.cond follows -> B.cond sees N=1 Z=0 (EX priority over MEM); arch_flags goes 0100 then 1000 on successive cycles.
6. COMMIT_STAGE=2, macro undefined, SUBS immediately followed by B.cond -> flag_stall high for 2 cycles, drops when arch_flags updates; reset asserted during stall -> flag_stall 0 and arch_flags 0000 next cycle.
